// File: rtl/fp_square_unit_if.sv
// rtl/fp_square_unit_if.sv - start/result handshake bundle for the floating-point squaring unit
interface fp_square_unit_if #(
    parameter int MW = 8,
    parameter int EW = 8
);
    logic                 DoSquare_i;
    logic                 DoInvSquare_i;
    logic                 s_i;
    logic [MW-1:0]        m_i;
    logic signed [EW-1:0] e_i;
    logic                 s_o;
    logic [MW-1:0]        m_o;
    logic signed [EW-1:0] e_o;
    logic                 valid_o;
    logic                 busy_o;
    logic                 ovf_o;
    logic                 zero_o;

    modport master (
        output DoSquare_i, DoInvSquare_i, s_i, m_i, e_i,
        input  s_o, m_o, e_o, valid_o, busy_o, ovf_o, zero_o
    );

    modport slave (
        input  DoSquare_i, DoInvSquare_i, s_i, m_i, e_i,
        output s_o, m_o, e_o, valid_o, busy_o, ovf_o, zero_o
    );
endinterface

// File: rtl/fp_square_unit.sv
// rtl/fp_square_unit.sv - iterative x^2 / 1/x^2 unit: normalise, shift-add multiply, round, restoring divide
module fp_square_unit #(
    parameter int MW = 8,
    parameter int EW = 8
) (
    input logic            clk,
    input logic            rst,
    fp_square_unit_if.slave bus
);
    localparam int XW = EW + 3;
    localparam int CW = $clog2(MW + 1);
    localparam logic signed [XW-1:0] E_ONE = XW'(1);
    localparam logic signed [XW-1:0] E_MAX = XW'(2 ** (EW - 1) - 1);
    localparam logic signed [XW-1:0] E_MIN = XW'(-(2 ** (EW - 1)));

    typedef enum logic [2:0] {
        S_IDLE,
        S_NORM,
        S_MUL,
        S_RND,
        S_DIV,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // working mantissa/exponent, reused as M/E after rounding and after division
    logic [MW-1:0]        m_q, m_d;
    logic signed [XW-1:0] e_q, e_d;
    // multiplier: shifted multiplicand, remaining multiplier bits, accumulated product
    logic [2*MW-1:0]      mc_q, mc_d;
    logic [MW-1:0]        mp_q, mp_d;
    logic [2*MW-1:0]      p_q, p_d;
    // divider: partial remainder (always < M) and quotient bits gathered so far
    logic [MW-1:0]        rem_q, rem_d;
    logic [MW-1:0]        q_q, q_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 inv_q, inv_d;
    logic                 zin_q, zin_d;

    logic [MW-1:0]        m_o_q, m_o_d;
    logic [EW-1:0]        e_o_q, e_o_d;
    logic                 valid_o_q, valid_o_d;
    logic                 busy_o_q, busy_o_d;
    logic                 ovf_o_q, ovf_o_d;
    logic                 zero_o_q, zero_o_d;

    logic                 start;
    logic [MW:0]          rnd_sum;
    logic signed [XW-1:0] e_rnd;
    logic [MW-1:0]        m_fin;
    logic signed [XW-1:0] e_fin;
    logic [MW:0]          rem_sh;
    logic                 q_bit;
    logic [MW:0]          q_full;
    logic                 unused_bits;

    // product bits below the rounding position and the input sign never affect the result
    assign unused_bits = ^{p_q[MW-3:0], bus.s_i};

    // next-state, datapath step and output staging
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        e_d       = e_q;
        mc_d      = mc_q;
        mp_d      = mp_q;
        p_d       = p_q;
        rem_d     = rem_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        inv_d     = inv_q;
        zin_d     = zin_q;
        m_o_d     = m_o_q;
        e_o_d     = e_o_q;
        ovf_o_d   = ovf_o_q;
        zero_o_d  = zero_o_q;
        valid_o_d = 1'b0;

        start = bus.DoSquare_i | bus.DoInvSquare_i;

        // round-to-nearest, ties up; the product may sit in [1,2) or [2,4)
        if (p_q[2*MW-1]) begin
            rnd_sum = {1'b0, p_q[2*MW-1:MW]} + {{MW{1'b0}}, p_q[MW-1]};
            e_rnd   = e_q + E_ONE;
        end else begin
            rnd_sum = {1'b0, p_q[2*MW-2:MW-1]} + {{MW{1'b0}}, p_q[MW-2]};
            e_rnd   = e_q;
        end
        m_fin = rnd_sum[MW] ? {1'b1, {(MW-1){1'b0}}} : rnd_sum[MW-1:0];
        e_fin = rnd_sum[MW] ? e_rnd + E_ONE : e_rnd;

        // one restoring-division step; dividend bits brought in are all zero
        rem_sh = {rem_q, 1'b0};
        q_bit  = (rem_sh >= {1'b0, m_q});
        q_full = {q_q, q_bit};

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    m_d     = bus.m_i;
                    e_d     = {{3{bus.e_i[EW-1]}}, bus.e_i};
                    inv_d   = ~bus.DoSquare_i;
                    zin_d   = (bus.m_i == '0);
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                if (zin_q) begin
                    state_d = S_RND;
                end else if (m_q[MW-1]) begin
                    mc_d    = {{MW{1'b0}}, m_q};
                    mp_d    = m_q;
                    p_d     = '0;
                    cnt_d   = '0;
                    e_d     = e_q <<< 1;
                    state_d = S_MUL;
                end else begin
                    m_d = m_q << 1;
                    e_d = e_q - E_ONE;
                end
            end
            S_MUL: begin
                if (mp_q[0]) begin
                    p_d = p_q + mc_q;
                end
                mc_d  = mc_q << 1;
                mp_d  = mp_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MW - 1)) begin
                    state_d = S_RND;
                end
            end
            S_RND: begin
                if (zin_q) begin
                    state_d = S_DONE;
                end else begin
                    m_d = m_fin;
                    e_d = e_fin;
                    if (inv_q) begin
                        rem_d   = {2'b01, {(MW-2){1'b0}}};
                        q_d     = '0;
                        cnt_d   = '0;
                        state_d = S_DIV;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DIV: begin
                rem_d = q_bit ? rem_sh[MW-1:0] - m_q : rem_sh[MW-1:0];
                q_d   = q_full[MW-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(MW)) begin
                    state_d = S_DONE;
                    if (q_full[MW]) begin
                        m_d = {1'b1, {(MW-1){1'b0}}};
                        e_d = -e_q;
                    end else begin
                        m_d = q_full[MW-1:0];
                        e_d = -e_q - E_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_o_d = (state_d != S_IDLE) && (state_d != S_DONE);

        // results and flags change only on the edge that raises valid_o
        if (state_d == S_DONE) begin
            valid_o_d = 1'b1;
            ovf_o_d   = 1'b0;
            zero_o_d  = 1'b0;
            if ((zin_q && inv_q) || (!zin_q && (e_d > E_MAX))) begin
                m_o_d   = '1;
                e_o_d   = E_MAX[EW-1:0];
                ovf_o_d = 1'b1;
            end else if (zin_q || (e_d < E_MIN)) begin
                m_o_d    = '0;
                e_o_d    = '0;
                zero_o_d = 1'b1;
            end else begin
                m_o_d = m_d;
                e_o_d = e_d[EW-1:0];
            end
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            e_q       <= '0;
            mc_q      <= '0;
            mp_q      <= '0;
            p_q       <= '0;
            rem_q     <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            inv_q     <= 1'b0;
            zin_q     <= 1'b0;
            m_o_q     <= '0;
            e_o_q     <= '0;
            valid_o_q <= 1'b0;
            busy_o_q  <= 1'b0;
            ovf_o_q   <= 1'b0;
            zero_o_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            e_q       <= e_d;
            mc_q      <= mc_d;
            mp_q      <= mp_d;
            p_q       <= p_d;
            rem_q     <= rem_d;
            q_q       <= q_d;
            cnt_q     <= cnt_d;
            inv_q     <= inv_d;
            zin_q     <= zin_d;
            m_o_q     <= m_o_d;
            e_o_q     <= e_o_d;
            valid_o_q <= valid_o_d;
            busy_o_q  <= busy_o_d;
            ovf_o_q   <= ovf_o_d;
            zero_o_q  <= zero_o_d;
        end
    end

    // squares are never negative
    assign bus.s_o     = 1'b0;
    assign bus.m_o     = m_o_q;
    assign bus.e_o     = e_o_q;
    assign bus.valid_o = valid_o_q;
    assign bus.busy_o  = busy_o_q;
    assign bus.ovf_o   = ovf_o_q;
    assign bus.zero_o  = zero_o_q;
endmodule

// File: tb/tb_fp_square_unit.sv
// tb/tb_fp_square_unit.sv - self-checking bench for fp_square_unit
module tb_fp_square_unit;
    localparam int MW = 8;
    localparam int EW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    fp_square_unit_if #(.MW(MW), .EW(EW)) bus ();
    fp_square_unit #(.MW(MW), .EW(EW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        int m;
        int e;
        bit ovf;
        bit zero;
        int lat;
    } res_t;

    typedef struct {
        bit inv;
        int m;
        int e;
        bit s;
        int xm;
        int xe;
        bit xovf;
        bit xz;
        int xlat;
    } dir_t;

    function automatic res_t model(input bit inv, input int m, input int e);
        res_t r;
        int k, mn, p, mm, ee, q;
        if (m == 0) begin
            r.lat = 2;
            if (inv) begin r.m = 255; r.e = 127; r.ovf = 1; r.zero = 0; end
            else     begin r.m = 0;   r.e = 0;   r.ovf = 0; r.zero = 1; end
            return r;
        end
        k = 0; mn = m;
        while (mn < 128) begin mn = mn * 2; k++; end
        p  = mn * mn;
        ee = 2 * (e - k);
        if (p >= 32768) begin mm = (p + 128) / 256; ee = ee + 1; end
        else            mm = (p + 64) / 128;
        if (mm == 256) begin mm = 128; ee = ee + 1; end
        if (inv) begin
            q = 32768 / mm;
            if (q == 256) begin mm = 128; ee = -ee; end
            else          begin mm = q;   ee = -ee - 1; end
        end
        r.lat = inv ? k + 19 : k + 10;
        if (ee > 127)       begin r.m = 255; r.e = 127; r.ovf = 1; r.zero = 0; end
        else if (ee < -128) begin r.m = 0;   r.e = 0;   r.ovf = 0; r.zero = 1; end
        else                begin r.m = mm;  r.e = ee;  r.ovf = 0; r.zero = 0; end
        return r;
    endfunction

    task automatic start_op(input bit sq, input bit inv, input int m, input int e, input bit s);
        bus.DoSquare_i    = sq;
        bus.DoInvSquare_i = inv;
        bus.m_i           = 8'(m);
        bus.e_i           = 8'(e);
        bus.s_i           = s;
        @(posedge clk); #1;
        bus.DoSquare_i    = 1'b0;
        bus.DoInvSquare_i = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (bus.valid_o) begin lat = n; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #3;
        checks++;
        if ({bus.valid_o, bus.busy_o, bus.ovf_o, bus.zero_o, bus.s_o, bus.m_o, bus.e_o} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b b=%b o=%b z=%b s=%b m=%h e=%h required all 0",
                     bus.valid_o, bus.busy_o, bus.ovf_o, bus.zero_o, bus.s_o, bus.m_o, bus.e_o);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        dir_t tbl [9];
        int   lat;
        tbl = '{
            '{0, 'h80,    0, 0, 'h80,   0, 0, 0, 10},
            '{0, 'hC0,    3, 1, 'h90,   7, 0, 0, 10},
            '{0, 'h40,    0, 0, 'h80,  -2, 0, 0, 11},
            '{1, 'hC0,    1, 0, 'hE3,  -4, 0, 0, 19},
            '{0, 'hB5,    0, 0, 'h80,   1, 0, 0, 10},
            '{0, 'hFF,  100, 0, 'hFF, 127, 1, 0, 10},
            '{0, 'h80, -100, 0, 'h00,   0, 0, 1, 10},
            '{1, 'h00,    5, 0, 'hFF, 127, 1, 0,  2},
            '{0, 'h00,    5, 1, 'h00,   0, 0, 1,  2}
        };
        foreach (tbl[i]) begin
            start_op(!tbl[i].inv, tbl[i].inv, tbl[i].m, tbl[i].e, tbl[i].s);
            wait_valid(lat);
            checks++;
            if (lat != tbl[i].xlat) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, tbl[i].xlat);
            end
            checks++;
            if ({bus.m_o, bus.e_o, bus.ovf_o, bus.zero_o, bus.s_o} !==
                {8'(tbl[i].xm), 8'(tbl[i].xe), tbl[i].xovf, tbl[i].xz, 1'b0}) begin
                failures++;
                $display("FAIL directed_result[%0d]: got m=%h e=%0d ovf=%b zero=%b s=%b required m=%h e=%0d ovf=%b zero=%b s=0",
                         i, bus.m_o, bus.e_o, bus.ovf_o, bus.zero_o, bus.s_o,
                         8'(tbl[i].xm), tbl[i].xe, tbl[i].xovf, tbl[i].xz);
            end
        end
    endtask

    task automatic test_random;
        int   lat, m, e;
        bit   inv;
        res_t r;
        for (int i = 0; i < 40; i++) begin
            inv = 1'($urandom_range(0, 1));
            m   = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            e   = int'($urandom_range(0, 255)) - 128;
            r   = model(inv, m, e);
            start_op(!inv, inv, m, e, 1'($urandom_range(0, 1)));
            checks++;
            if (bus.busy_o !== 1'b1) begin
                failures++;
                $display("FAIL random_busy[%0d]: got %b required 1", i, bus.busy_o);
            end
            wait_valid(lat);
            checks++;
            if (lat != r.lat) begin
                failures++;
                $display("FAIL random_latency[%0d] inv=%b m=%h e=%0d: got %0d required %0d", i, inv, m, e, lat, r.lat);
            end
            checks++;
            if ({bus.m_o, bus.e_o, bus.ovf_o, bus.zero_o, bus.s_o} !== {8'(r.m), 8'(r.e), r.ovf, r.zero, 1'b0}) begin
                failures++;
                $display("FAIL random_result[%0d] inv=%b m=%h e=%0d: got m=%h e=%0d ovf=%b zero=%b s=%b required m=%h e=%0d ovf=%b zero=%b s=0",
                         i, inv, m, e, bus.m_o, bus.e_o, bus.ovf_o, bus.zero_o, bus.s_o, 8'(r.m), r.e, r.ovf, r.zero);
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lat, extra;
        start_op(1, 0, 'hC0, 3, 0);
        lat = -1;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (n == 3) begin
                bus.DoSquare_i = 1'b1; bus.DoInvSquare_i = 1'b1;
                bus.m_i = 8'h40; bus.e_i = 8'd0;
            end
            if (n == 4) begin
                bus.DoSquare_i = 1'b0; bus.DoInvSquare_i = 1'b0;
            end
            if (bus.valid_o) begin lat = n; break; end
        end
        checks++;
        if (lat != 10) begin
            failures++;
            $display("FAIL busy_ignore_latency: got %0d required 10", lat);
        end
        checks++;
        if ({bus.m_o, bus.e_o, bus.ovf_o, bus.zero_o} !== {8'h90, 8'd7, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL busy_ignore_result: got m=%h e=%0d required m=90 e=7", bus.m_o, bus.e_o);
        end
        extra = 0;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (bus.valid_o || bus.busy_o) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL busy_ignore_no_restart: got %0d active cycles required 0", extra);
        end
    endtask

    task automatic test_reset_mid;
        int lat, seen;
        start_op(1, 0, 'hC0, 3, 0);
        wait_valid(lat);
        start_op(0, 1, 'hA0, 2, 0);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.valid_o, bus.busy_o, bus.ovf_o, bus.zero_o, bus.s_o, bus.m_o, bus.e_o} !== 21'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got v=%b b=%b m=%h e=%h required all 0",
                     bus.valid_o, bus.busy_o, bus.m_o, bus.e_o);
        end
        @(negedge clk); rst = 1'b1;
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk); #1;
            if (bus.valid_o) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_mid_no_valid: got %0d valid pulses required 0", seen);
        end
    endtask

    task automatic test_both_starts;
        int lat;
        start_op(1, 1, 'hC0, 1, 0);
        wait_valid(lat);
        checks++;
        if (lat != 10 || {bus.m_o, bus.e_o, bus.ovf_o, bus.zero_o} !== {8'h90, 8'd3, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL both_starts: got lat=%0d m=%h e=%0d required lat=10 m=90 e=3", lat, bus.m_o, bus.e_o);
        end
    endtask

    task automatic test_back_to_back;
        int   lat;
        res_t ra, rb;
        ra = model(1, 'hC0, 1);
        rb = model(0, 'h40, 0);
        start_op(0, 1, 'hC0, 1, 0);
        wait_valid(lat);
        checks++;
        if (lat != ra.lat || bus.m_o !== 8'(ra.m) || bus.e_o !== 8'(ra.e)) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d m=%h e=%0d required lat=%0d m=%h e=%0d",
                     lat, bus.m_o, bus.e_o, ra.lat, 8'(ra.m), ra.e);
        end
        start_op(1, 0, 'h40, 0, 0);
        checks++;
        if (bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_restart: got busy=%b valid=%b required busy=1 valid=0", bus.busy_o, bus.valid_o);
        end
        wait_valid(lat);
        checks++;
        if (lat != rb.lat || bus.m_o !== 8'(rb.m) || bus.e_o !== 8'(rb.e)) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d m=%h e=%0d required lat=%0d m=%h e=%0d",
                     lat, bus.m_o, bus.e_o, rb.lat, 8'(rb.m), rb.e);
        end
    endtask

    initial begin
        bus.DoSquare_i    = 1'b0;
        bus.DoInvSquare_i = 1'b0;
        bus.s_i           = 1'b0;
        bus.m_i           = '0;
        bus.e_i           = '0;
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_mid();
        test_both_starts();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fp_square_unit.md
Name: fp_square_unit

Overview:
- Sequential floating-point squaring unit. It is the inverse-direction companion of the SQRT_Floating_Point block: it computes x^2 (DoSquare_i) or 1/x^2 (DoInvSquare_i).
- It uses the same sign/mantissa/exponent format and the same Do*/valid_o handshake, so SQRT results can be round-tripped in the datapath.
- Multi-cycle datapath: iterative pre-normalise, then shift-add multiply, then round, then an optional restoring divide.

Parameters:
- MW, 8, mantissa width. Value = m/2^(MW-1); normalised means m[MW-1]=1, i.e. value in [1,2).
- EW, 8, signed exponent width. Internal exponent arithmetic is EW+3 bits signed.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- DoSquare_i  in  1  start pulse for the square operation.
- DoInvSquare_i  in  1  start pulse for the inverse-square operation.
- s_i  in  1  input sign (ignored: the result is always positive).
- m_i  in  MW  input mantissa (may be unnormalised).
- e_i  in  EW signed  input exponent.
- s_o  out  1  result sign, always 0.
- m_o  out  MW  result mantissa, normalised unless zero_o=1.
- e_o  out  EW signed  result exponent.
- valid_o  out  1  one-cycle pulse; result is valid in that cycle.
- busy_o  out  1  high from the start-sampling edge until valid_o.
- ovf_o  out  1  overflow or divide-by-zero saturation occurred.
- zero_o  out  1  result is zero (zero input, or underflow flush).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, and every output is 0.
  - Reset mid-operation aborts the operation; no valid_o is produced for it.
- States and transitions: IDLE -> NORM -> MUL -> RND -> (DIV) -> DONE -> IDLE.
- IDLE:
  - Samples start when DoSquare_i|DoInvSquare_i is high; latches m_i, e_i and the op.
  - If both are high, square wins.
  - Start inputs are ignored whenever busy_o=1.
  - Outputs hold their last result until the next valid_o.
- Zero input (m_i=0):
  - Square: m_o=0, e_o=0, zero_o=1.
  - InvSquare: m_o=all-ones, e_o=+max, ovf_o=1.
  - Both go straight to DONE, with valid_o 2 cycles after the start edge.
- NORM: one left shift of m and e-=1 per cycle until m[MW-1]=1. k = leading-zero count, 0..MW-1 cycles.
- MUL: MW cycles of shift-add, giving the 2MW-bit product P = m*m (value P/2^(2MW-2), in [1,4)). Exponent E = 2e.
- RND (1 cycle), round-to-nearest with ties rounding up:
  - If P[2MW-1]=1: M = P[2MW-1:MW] + P[MW-1], E += 1.
  - Else: M = P[2MW-2:MW-1] + P[MW-2].
  - If the rounding carry overflows: M = 1000..0, E += 1.
- DIV (InvSquare only), MW+1 cycles restoring division: Q = floor(2^(2MW-1)/M), so Q is in (2^MW/2, 2^MW].
  - If Q = 2^MW: M = 100..0, E = -E.
  - Else: M = Q[MW-1:0], E = -E-1. Truncated, no rounding.
- DONE (1 cycle): saturate, drive the outputs, pulse valid_o, clear busy_o, then go to IDLE.
  - E > 2^(EW-1)-1: m_o=all-ones, e_o=+max, ovf_o=1.
  - E < -2^(EW-1): flush to m_o=0, e_o=0, zero_o=1.
- Flags ovf_o and zero_o are updated only at valid_o.
- Latency (start edge to valid_o high), nonzero input:
  - Square: k+MW+2 edges = k+10 for MW=8.
  - InvSquare: k+2MW+3 edges = k+19.
- A new start may be sampled on the edge at which valid_o is high (busy_o=0 in DONE-exit cycle): this gives back-to-back operation.

Test Plan:
- Square, m_i=0x80, e_i=0 -> m_o=0x80, e_o=0, s_o=0; valid_o exactly 10 edges after start.
- Square, m_i=0xC0 (1.5), e_i=3, s_i=1 -> m_o=0x90 (1.125), e_o=7, s_o=0.
- Square, m_i=0x40 (0.5), e_i=0 -> k=1, m_o=0x80, e_o=-2; latency 11.
- InvSquare, m_i=0xC0, e_i=1 -> M=0x90, E=3, Q=227, so m_o=0xE3, e_o=-4 (~0.1108 vs 1/9); latency 19.
- Boundary cases:
  - Square, m_i=0xB5, e_i=0 -> rounding carry gives m_o=0x80, e_o=1.
  - Square, m_i=0xFF, e_i=100 -> ovf_o=1, m_o=0xFF, e_o=127.
  - Square, e_i=-100 -> zero_o=1.
  - InvSquare, m_i=0 -> ovf_o=1, valid_o after 2 edges.
- Control cases:
  - DoSquare_i pulse while busy_o=1 -> ignored, and the first result is unchanged.
  - rst pulled low during MUL -> all outputs 0 immediately, and no valid_o.
  - Both Do* high together -> square is performed.
